// File: rtl/alu_pkg.sv
// Shared types and constants for the accumulator ALU datapath.
package alu_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    SRC_IMM  = 2'b00,
    SRC_REG  = 2'b01,
    SRC_MEM  = 2'b10,
    SRC_NONE = 2'b11
  } data_src_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_ADC = 3'b001,
    OP_SUB = 3'b010,
    OP_SBB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_LD  = 3'b111
  } alu_op_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU: accumulator A, operand B and carry-in C to result, carry and overflow.
module alu_comb
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c,
  input  alu_op_t      op,
  output logic [W-1:0] result,
  output logic         cy,
  output logic         o
);

  logic [W:0] sum_ext;
  logic [W:0] diff_ext;
  logic       cin_add;
  logic       cin_sub;

  assign cin_add = (op == OP_ADC) ? c : 1'b0;
  assign cin_sub = (op == OP_SBB) ? c : 1'b0;

  // Bit W of the widened difference wraps to 1 exactly when a borrow occurs.
  assign sum_ext  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin_add};
  assign diff_ext = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin_sub};

  always_comb begin
    result = b;
    cy     = 1'b0;
    o      = 1'b0;
    unique case (op)
      OP_ADD, OP_ADC: begin
        result = sum_ext[W-1:0];
        cy     = sum_ext[W];
        o      = (a[W-1] == b[W-1]) && (sum_ext[W-1] != a[W-1]);
      end
      OP_SUB, OP_SBB: begin
        result = diff_ext[W-1:0];
        cy     = diff_ext[W];
        o      = (a[W-1] != b[W-1]) && (diff_ext[W-1] != a[W-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_LD:  result = b;
      default: result = b;
    endcase
  end

endmodule

// File: rtl/alu_acc_flags_core.sv
// Operand mux, accumulator and carry/overflow registers around alu_comb; Z/S decode the accumulator.
module alu_acc_flags_core
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  data_src_t        data_src,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] reg_out,
  input  logic [WIDTH-1:0] mem_out,
  input  logic [2:0]       op,
  input  logic             ce_a,
  input  logic             ce_cy,
  output logic [WIDTH-1:0] alu_in,
  output logic [WIDTH-1:0] acc_v,
  output logic             flag_cy,
  output logic             flag_z,
  output logic             flag_s,
  output logic             flag_o
);

  logic [WIDTH-1:0] acc_reg;
  logic             cy_reg;
  logic             o_reg;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cy;
  logic             alu_o;
  alu_op_t          op_dec;

  assign op_dec = alu_op_t'(op);

  always_comb begin
    alu_in = '0;
    unique case (data_src)
      SRC_IMM:  alu_in = immediate;
      SRC_REG:  alu_in = reg_out;
      SRC_MEM:  alu_in = mem_out;
      SRC_NONE: alu_in = '0;
      default:  alu_in = '0;
    endcase
  end

  alu_comb #(.W(WIDTH)) u_alu (
    .a      (acc_reg),
    .b      (alu_in),
    .c      (cy_reg),
    .op     (op_dec),
    .result (alu_result),
    .cy     (alu_cy),
    .o      (alu_o)
  );

  // LD moves data only; it never disturbs the carry/overflow pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      cy_reg  <= 1'b0;
      o_reg   <= 1'b0;
    end else begin
      if (ce_a) begin
        acc_reg <= alu_result;
      end
      if (ce_cy && (op_dec != OP_LD)) begin
        cy_reg <= alu_cy;
        o_reg  <= alu_o;
      end
    end
  end

  assign acc_v   = acc_reg;
  assign flag_cy = cy_reg;
  assign flag_o  = o_reg;
  assign flag_z  = (acc_reg == '0);
  assign flag_s  = acc_reg[WIDTH-1];

endmodule

// File: tb/tb_alu_acc_flags_core.sv
// Directed-vector bench for alu_acc_flags_core with hand-computed expectations.
module tb_alu_acc_flags_core;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  data_src_t  data_src;
  logic [7:0] immediate;
  logic [7:0] reg_out;
  logic [7:0] mem_out;
  logic [2:0] op;
  logic       ce_a;
  logic       ce_cy;
  logic [7:0] alu_in;
  logic [7:0] acc_v;
  logic       flag_cy;
  logic       flag_z;
  logic       flag_s;
  logic       flag_o;

  int vectors_cnt;
  int miscompare_cnt;

  alu_acc_flags_core dut (
    .clk       (clk),
    .rst       (rst),
    .data_src  (data_src),
    .immediate (immediate),
    .reg_out   (reg_out),
    .mem_out   (mem_out),
    .op        (op),
    .ce_a      (ce_a),
    .ce_cy     (ce_cy),
    .alu_in    (alu_in),
    .acc_v     (acc_v),
    .flag_cy   (flag_cy),
    .flag_z    (flag_z),
    .flag_s    (flag_s),
    .flag_o    (flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%02h", tag, obs);
    end
  endtask

  // Apply one instruction, clock it in, and leave time 1ns past the edge.
  task automatic apply(input data_src_t src, input logic [7:0] b, input logic [2:0] opc,
                       input logic a_en, input logic cy_en);
    data_src  = src;
    immediate = (src == SRC_IMM) ? b : 8'h00;
    reg_out   = (src == SRC_REG) ? b : 8'h00;
    mem_out   = (src == SRC_MEM) ? b : 8'h00;
    op        = opc;
    ce_a      = a_en;
    ce_cy     = cy_en;
    @(posedge clk);
    #1;
    ce_a  = 1'b0;
    ce_cy = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_acc, input logic e_cy,
                           input logic e_z, input logic e_s, input logic e_o);
    check({tag, ".acc"}, acc_v, e_acc);
    check({tag, ".cy"}, {7'd0, flag_cy}, {7'd0, e_cy});
    check({tag, ".z"}, {7'd0, flag_z}, {7'd0, e_z});
    check({tag, ".s"}, {7'd0, flag_s}, {7'd0, e_s});
    check({tag, ".o"}, {7'd0, flag_o}, {7'd0, e_o});
  endtask

  initial begin
    vectors_cnt    = 0;
    miscompare_cnt = 0;
    rst       = 1'b1;
    data_src  = SRC_IMM;
    immediate = 8'h00;
    reg_out   = 8'h00;
    mem_out   = 8'h00;
    op        = 3'b000;
    ce_a      = 1'b0;
    ce_cy     = 1'b0;

    #3;
    check_all("reset_async", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("reset_idle", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Signed overflow on 0x7F + 1
    apply(SRC_IMM, 8'h7F, 3'b111, 1'b1, 1'b0);
    check("ld_7f.acc", acc_v, 8'h7F);
    apply(SRC_IMM, 8'h01, 3'b000, 1'b1, 1'b1);
    check_all("add_ovf", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);

    // Unsigned carry-out via register source, then ADC from memory
    apply(SRC_IMM, 8'hFF, 3'b111, 1'b1, 1'b0);
    check("ld_ff.acc", acc_v, 8'hFF);
    apply(SRC_REG, 8'h01, 3'b000, 1'b1, 1'b1);
    check_all("add_wrap", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(SRC_MEM, 8'h10, 3'b001, 1'b1, 1'b1);
    check_all("adc_mem", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

    // Borrow, then SBB consuming it
    apply(SRC_IMM, 8'h00, 3'b111, 1'b1, 1'b0);
    apply(SRC_IMM, 8'h01, 3'b010, 1'b1, 1'b1);
    check_all("sub_borrow", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    apply(SRC_IMM, 8'h00, 3'b011, 1'b1, 1'b1);
    check_all("sbb", 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flag-only SUB sets borrow without touching acc; logic ops then clear it
    apply(SRC_IMM, 8'hF0, 3'b111, 1'b1, 1'b0);
    apply(SRC_IMM, 8'hF1, 3'b010, 1'b0, 1'b1);
    check_all("sub_flags_only", 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
    apply(SRC_IMM, 8'h3C, 3'b100, 1'b1, 1'b1);
    check_all("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(SRC_IMM, 8'h0F, 3'b101, 1'b1, 1'b1);
    check("or.acc", acc_v, 8'h3F);
    apply(SRC_IMM, 8'h3F, 3'b110, 1'b1, 1'b1);
    check_all("xor", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Operand mux is combinational and independent of the enables
    data_src = SRC_REG; reg_out = 8'hA5; #1;
    check("mux_reg", alu_in, 8'hA5);
    data_src = SRC_MEM; mem_out = 8'h5A; #1;
    check("mux_mem", alu_in, 8'h5A);
    data_src = SRC_NONE; immediate = 8'h77; #1;
    check("mux_none", alu_in, 8'h00);
    data_src = SRC_IMM; #1;
    check("mux_imm", alu_in, 8'h77);
    op = 3'b000;
    @(posedge clk); #1;
    check("hold_noce.acc", acc_v, 8'h00);

    // LD with ce_cy must not overwrite the carry
    apply(SRC_IMM, 8'h01, 3'b010, 1'b0, 1'b1);
    check("set_cy.cy", {7'd0, flag_cy}, 8'h01);
    apply(SRC_IMM, 8'h55, 3'b111, 1'b1, 1'b1);
    check_all("ld_holds_cy", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);

    // Async reset between edges with an enabled ADD pending
    data_src = SRC_IMM; immediate = 8'h01; op = 3'b000; ce_a = 1'b1; ce_cy = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_all("rst_midcycle", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rst_held.acc", acc_v, 8'h00);
    ce_a = 1'b0; ce_cy = 1'b0;
    #2;
    rst = 1'b0;
    apply(SRC_IMM, 8'h01, 3'b000, 1'b1, 1'b0);
    check("post_rst_add.acc", acc_v, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_cnt, miscompare_cnt);
    $finish;
  end

endmodule

// File: doc/alu_acc_flags_core.md
Name: alu_acc_flags_core

Overview:
- 8-bit ALU with a registered accumulator and status flags, for the lab CPU datapath.
- Selects operand B from immediate, register file or data memory (exported as alu_in).
- Combines B with the accumulator per op, and writes the result and carry/overflow under separate clock enables.
- Zero/sign flags reflect the accumulator contents.

Parameters:
- WIDTH, 8, datapath width (all data ports and accumulator).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- data_src  in  data_src_t (2)  operand B source select
- immediate  in  8  immediate operand from instruction
- reg_out  in  8  register-file read data
- mem_out  in  8  data-memory read data
- op  in  3  ALU operation code
- ce_a  in  1  accumulator write enable
- ce_cy  in  1  carry/overflow flag write enable
- alu_in  out  8  selected operand B (combinational)
- acc_v  out  8  accumulator value (registered)
- flag_cy  out  1  carry/borrow flag (registered)
- flag_z  out  1  zero flag, acc_v == 0
- flag_s  out  1  sign flag, acc_v[7]
- flag_o  out  1  signed overflow flag (registered)

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset: acc_v=0x00, flag_cy=0, flag_o=0, hence flag_z=1, flag_s=0. Reset asserted mid-operation overrides any pending enable immediately.
- Operand mux (combinational): SRC_IMM(2'b00)->immediate, SRC_REG(2'b01)->reg_out, SRC_MEM(2'b10)->mem_out, 2'b11->0x00.
- Let A=acc_v, B=alu_in, C=flag_cy. Results are computed 9-bit; result = low 8 bits, carry = bit 8.
- 000 ADD: A+B; cy=carry-out.
- 001 ADC: A+B+C; cy=carry-out.
- 010 SUB: A-B; cy=borrow (1 when A<B unsigned).
- 011 SBB: A-B-C; cy=borrow.
- 100 AND: A&B; cy=0, o=0.
- 101 OR: A|B; cy=0, o=0.
- 110 XOR: A^B; cy=0, o=0.
- 111 LD: B; cy and o hold (not written even if ce_cy).
- Overflow for add ops: (A[7]==B[7]) && (R[7]!=A[7]).
- Overflow for sub ops: (A[7]!=B[7]) && (R[7]!=A[7]).
- Latency:
  - On a rising edge with ce_a=1, acc_v<=result. ce_a=0 holds acc_v.
  - On a rising edge with ce_cy=1, flag_cy/flag_o <= computed values (LD excepted). ce_cy=0 holds both.
  - ce_a and ce_cy are independent: either, both or neither may be set. Both set in the same cycle use the same pre-edge A and C.
- flag_z and flag_s are combinational from acc_v and therefore update in the same cycle acc_v changes.
- Wrap-around is modulo 256; no saturation.
- Unknown/illegal op values do not exist (3-bit fully decoded).

Decomposition:
- Package alu_pkg:
  - typedef enum logic[1:0] data_src_t {SRC_IMM, SRC_REG, SRC_MEM, SRC_NONE}.
  - typedef enum logic[2:0] alu_op_t with the eight opcodes above.
  - WIDTH constant.
- One natural sub-module, alu_comb: purely combinational A/B/C/op -> result, cy, o.
- The top holds the operand mux, accumulator and flag registers.

Test Plan:
- Reset then idle -> acc_v=0x00, flag_z=1, flag_s=0, flag_cy=0, flag_o=0.
- LD imm 0x7F (ce_a=1), then ADD imm 0x01 (ce_a=1, ce_cy=1) -> acc_v=0x80, flag_s=1, flag_z=0, flag_o=1, flag_cy=0.
- acc_v=0xFF, ADD reg_out=0x01 (SRC_REG) -> acc_v=0x00, flag_z=1, flag_cy=1, flag_o=0. Next ADC mem_out=0x10 (SRC_MEM) -> acc_v=0x11, flag_cy=0.
- acc_v=0x00, SUB imm 0x01 -> acc_v=0xFF, flag_cy=1, flag_s=1. Then SBB imm 0x00 -> acc_v=0xFE, flag_cy=0.
- acc_v=0xF0: AND 0x3C -> 0x30; OR 0x0F -> 0x3F; XOR 0x3F -> 0x00 with flag_z=1, flag_cy=0. With ce_a=0, alu_in tracks the mux while acc_v is unchanged.
- Assert rst asynchronously between edges while acc_v=0x55, flag_cy=1 -> outputs drop to reset values before the next clk edge. After release, the first enabled ADD 0x01 gives acc_v=0x01.
